// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one load/store at a time, LATENCY wait states, valid/ready response.
// Optional macro DMEM_MISALIGN_ERR_EN flags misaligned half/word accesses instead of forcing alignment.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_wr_ctrl,
    input  logic [2:0]  req_rd_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT         state;
    logic [3:0]    waitCnt;
    logic          readyReg;
    logic          validReg;
    logic [31:0]   rdataReg;
    logic          errReg;

    logic          weReg;
    logic [AW+1:0] addrReg;
    logic [31:0]   wdataReg;
    logic [1:0]    wrCtrlReg;
    logic [2:0]    rdCtrlReg;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] wordIdx;
    logic          accByte;
    logic          accHalf;
    logic          misaligned;
    logic          commit;
    logic          memWrite;
    logic [3:0]    byteEn;
    logic [31:0]   wdataLane;
    logic [31:0]   memWord;
    logic [7:0]    loadByte;
    logic [15:0]   loadHalf;
    logic          loadSigned;
    logic [31:0]   loadValue;
    logic          unusedAddr;

    // Address bits above the array size wrap and are deliberately dropped.
    assign unusedAddr = ^req_addr[31:AW+2];

    assign wordIdx = addrReg[AW+1:2];
    assign accByte = weReg ? (wrCtrlReg == 2'b00)
                           : (rdCtrlReg == 3'b000 || rdCtrlReg == 3'b100);
    assign accHalf = weReg ? (wrCtrlReg == 2'b01)
                           : (rdCtrlReg == 3'b001 || rdCtrlReg == 3'b101);

`ifdef DMEM_MISALIGN_ERR_EN
    assign misaligned = accHalf ? addrReg[0]
                      : accByte ? 1'b0
                      : (addrReg[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Lane steering ignores the low address bits below the access size, giving forced alignment.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            assign byteEn[gi] = accByte ? (addrReg[1:0] == 2'(gi))
                              : accHalf ? (addrReg[1] == 1'(gi / 2))
                              : 1'b1;
            assign wdataLane[gi*8 +: 8] = accByte ? wdataReg[7:0]
                                        : accHalf ? wdataReg[(gi % 2)*8 +: 8]
                                        : wdataReg[gi*8 +: 8];
        end
    endgenerate

    assign memWord    = mem[wordIdx];
    assign loadByte   = memWord[{addrReg[1:0], 3'b000} +: 8];
    assign loadHalf   = addrReg[1] ? memWord[31:16] : memWord[15:0];
    assign loadSigned = ~rdCtrlReg[2];
    assign loadValue  = accByte ? {{24{loadSigned & loadByte[7]}}, loadByte}
                      : accHalf ? {{16{loadSigned & loadHalf[15]}}, loadHalf}
                      : memWord;

    assign commit   = (state == WAIT) && (waitCnt == 4'd0);
    // Gated by rst so a reset landing on the commit edge drops the store.
    assign memWrite = rst && commit && weReg && !misaligned;

    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][b*8 +: 8] <= wdataLane[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            waitCnt  <= 4'd0;
            readyReg <= 1'b0;
            validReg <= 1'b0;
            rdataReg <= 32'd0;
            errReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && readyReg) begin
                        weReg     <= req_we;
                        addrReg   <= req_addr[AW+1:0];
                        wdataReg  <= req_wdata;
                        wrCtrlReg <= req_wr_ctrl;
                        rdCtrlReg <= req_rd_ctrl;
                        waitCnt   <= 4'(LATENCY - 1);
                        readyReg  <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        readyReg  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd0) begin
                        validReg <= 1'b1;
                        errReg   <= misaligned;
                        rdataReg <= (weReg || misaligned) ? 32'd0 : loadValue;
                        state    <= RESP;
                    end else begin
                        waitCnt  <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        validReg <= 1'b0;
                        rdataReg <= 32'd0;
                        errReg   <= 1'b0;
                        readyReg <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    readyReg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = readyReg;
    assign rsp_valid = validReg;
    assign rsp_rdata = rdataReg;
    assign rsp_err   = errReg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model of the memory.
module tb_dmem_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int MEMB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_wr_ctrl = 2'd0;
    logic [2:0]  req_rd_ctrl = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int txnNo = 0;
    int prevAccept = -1;
    int prevStall = 0;
    byte unsigned mref [MEMB];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wr_ctrl(req_wr_ctrl), .req_rd_ctrl(req_rd_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int accSize(input bit we, input logic [1:0] wc, input logic [2:0] rc);
        if (we) return (wc == 2'd0) ? 1 : (wc == 2'd1) ? 2 : 4;
        if (rc == 3'b000 || rc == 3'b100) return 1;
        if (rc == 3'b001 || rc == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit isMisaligned(input int size, input logic [31:0] addr);
        int lo;
        lo = int'(addr[1:0]);
`ifdef DMEM_MISALIGN_ERR_EN
        return (lo % size) != 0;
`else
        return (lo < 0);
`endif
    endfunction

    // Reference: memory as bytes, address reduced modulo the array, rounded down to the access size.
    task automatic modelTxn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] wc, input logic [2:0] rc,
                            output logic [31:0] expData, output logic expErr);
        int size;
        int base;
        logic [31:0] v;
        bit sgn;
        size = accSize(we, wc, rc);
        base = int'(addr % 32'(MEMB));
        base = base - (base % size);
        expErr = isMisaligned(size, addr);
        expData = 32'd0;
        if (!expErr) begin
            if (we) begin
                for (int i = 0; i < size; i++) mref[base + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = mref[base + i];
                sgn = (rc == 3'b000 || rc == 3'b001);
                if (size == 1 && sgn && v[7])  v[31:8]  = 24'hFFFFFF;
                if (size == 2 && sgn && v[15]) v[31:16] = 16'hFFFF;
                expData = v;
            end
        end
    endtask

    task automatic driveJunk();
        req_valid   = 1'($urandom_range(0, 1));
        req_we      = 1'($urandom_range(0, 1));
        req_addr    = $urandom();
        req_wdata   = $urandom();
        req_wr_ctrl = 2'($urandom_range(0, 3));
        req_rd_ctrl = 3'($urandom_range(0, 7));
    endtask

    // Presents a request at a negedge and returns at the negedge after the accepting edge.
    task automatic acceptReq(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] wc, input logic [2:0] rc, output bit ok);
        int guard;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_wr_ctrl = wc; req_rd_ctrl = rc;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        ok = (req_ready === 1'b1);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic runTxn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] wc, input logic [2:0] rc, input int stall,
                          output logic [31:0] gotData, output logic gotErr);
        bit ok;
        int lat;
        int acc;
        logic [31:0] d0;
        logic e0;
        gotData = 32'd0;
        gotErr = 1'b0;
        acceptReq(we, addr, wdata, wc, rc, ok);
        if (!ok) return;
        acc = cycle;
        if (prevAccept >= 0) check("throughput", 32'(acc - prevAccept), 32'(LATENCY + 2 + prevStall));
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            check("busy_ready", 32'(req_ready), 32'd0);
            driveJunk();
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        if (rsp_valid !== 1'b1) begin
            req_valid = 1'b0;
            prevAccept = -1;
            return;
        end
        d0 = rsp_rdata;
        e0 = rsp_err;
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            driveJunk();
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", rsp_rdata, d0);
            check("stall_err", 32'(rsp_err), 32'(e0));
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        gotData = rsp_rdata;
        gotErr = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_data", rsp_rdata, 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
        prevAccept = acc;
        prevStall = stall;
    endtask

    task automatic doTxn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] wc, input logic [2:0] rc, input int stall,
                         input bit hasConst, input logic [31:0] constData);
        logic [31:0] gotD, expD;
        logic gotE, expE;
        runTxn(we, addr, wdata, wc, rc, stall, gotD, gotE);
        modelTxn(we, addr, wdata, wc, rc, expD, expE);
        txnNo++;
        $display("TXN %0d we=%0b addr=%h wdata=%h wc=%0d rc=%0d stall=%0d rdata=%h err=%0b exp=%h/%0b",
                 txnNo, we, addr, wdata, wc, rc, stall, gotD, gotE, expD, expE);
        check("rdata", gotD, expD);
        check("err", 32'(gotE), 32'(expE));
        if (hasConst) check("directed", gotD, constData);
    endtask

    task automatic doReset(input int n);
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_valid", 32'(rsp_valid), 32'd0);
            check("rst_data", rsp_rdata, 32'd0);
            check("rst_err", 32'(rsp_err), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_valid", 32'(rsp_valid), 32'd0);
        prevAccept = -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        logic [31:0] misExp;

        doReset(3);

        for (int w = 0; w < DEPTH; w++) doTxn(1'b1, 32'(w * 4), $urandom(), 2'b10, 3'b010, 0, 1'b0, 32'd0);

        doTxn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 3'b010, 0, 1'b0, 32'd0);
        doTxn(1'b0, 32'h10, 32'd0,        2'b10, 3'b010, 0, 1'b1, 32'hDEADBEEF);
        doTxn(1'b1, 32'h13, 32'h00000080, 2'b00, 3'b010, 0, 1'b0, 32'd0);
        doTxn(1'b0, 32'h13, 32'd0,        2'b00, 3'b000, 0, 1'b1, 32'hFFFFFF80);
        doTxn(1'b0, 32'h13, 32'd0,        2'b00, 3'b100, 0, 1'b1, 32'h00000080);
        doTxn(1'b0, 32'h10, 32'd0,        2'b00, 3'b010, 5, 1'b1, 32'h80ADBEEF);
        doTxn(1'b0, 32'h12, 32'd0,        2'b00, 3'b001, 0, 1'b1, 32'hFFFF80AD);
        doTxn(1'b1, 32'h400, 32'h11111111, 2'b10, 3'b010, 0, 1'b0, 32'd0);
        doTxn(1'b0, 32'h0, 32'd0,          2'b10, 3'b010, 0, 1'b1, 32'h11111111);

        // Store aborted by reset while waiting: must not reach the array.
        acceptReq(1'b1, 32'h0, 32'h22222222, 2'b10, 3'b010, ok);
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        prevAccept = -1;
        doTxn(1'b0, 32'h0, 32'd0, 2'b10, 3'b010, 0, 1'b1, 32'h11111111);

        // Load response discarded by reset while pending.
        acceptReq(1'b0, 32'h10, 32'd0, 2'b10, 3'b010, ok);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("resp_rst_latency", 32'(lat), 32'(LATENCY));
        rst = 1'b0;
        @(negedge clk);
        check("resp_rst_valid", 32'(rsp_valid), 32'd0);
        check("resp_rst_data", rsp_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("resp_rst_ready", 32'(req_ready), 32'd1);
        prevAccept = -1;

`ifdef DMEM_MISALIGN_ERR_EN
        misExp = 32'd0;
`else
        misExp = 32'h80ADBEEF;
`endif
        doTxn(1'b0, 32'h12, 32'd0, 2'b10, 3'b010, 0, 1'b1, misExp);

        for (int t = 0; t < 400; t++) begin
            doTxn(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                  1'b0, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
